// File: rtl/check_data_packet_pkg.sv
// Shared types, default markers and the payload pattern function for the packet checker.
package check_data_packet_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StPayload,
    StFooter
  } state_e;

  localparam logic [31:0] DEFAULT_HEADER = 32'hAAAAAAAA;
  localparam logic [31:0] DEFAULT_FOOTER = 32'hF0F0F0F0;

  // Payload word k carries {2k+1, 2k} in its two halves.
  function automatic logic [31:0] expected_word(input logic [7:0] idx);
    logic [15:0] w_lo;
    w_lo = {7'd0, idx, 1'b0};
    return {w_lo | 16'd1, w_lo};
  endfunction

endpackage

// File: rtl/check_data_packet_sat_counter.sv
// Saturating up-counter; clear wins over a same-cycle increment.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [Width-1:0] o_cnt
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + Width'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/check_data_packet.sv
// Receive-side checker: hunts for the header, verifies payload pattern and footer, tracks lock.
// Optional first-mismatch capture ports are enabled by CHECK_DATA_PACKET_ERR_CAPTURE_EN.
module check_data_packet
  import check_data_packet_pkg::*;
#(
  parameter int unsigned PAYLOAD_WORDS  = 24,
  parameter logic [31:0] HEADER_WORD    = DEFAULT_HEADER,
  parameter logic [31:0] FOOTER_WORD    = DEFAULT_FOOTER,
  parameter int unsigned LOCK_THRESHOLD = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DATA_IN,
  input  logic        DATA_VALID,
  input  logic        CLR_CNT,
  output logic        LOCKED,
  output logic        PKT_OK,
  output logic        PKT_ERR,
  output logic [31:0] PKT_CNT,
  output logic [31:0] ERR_CNT,
  output logic [31:0] WORD_ERR_CNT
`ifdef CHECK_DATA_PACKET_ERR_CAPTURE_EN
  ,
  output logic [7:0]  ERR_IDX,
  output logic [31:0] ERR_EXP,
  output logic [31:0] ERR_GOT,
  output logic        ERR_VALID
`endif
);

  localparam logic [7:0] LastIdx = 8'(PAYLOAD_WORDS - 1);
  localparam logic [7:0] LockTh  = 8'(LOCK_THRESHOLD);

  state_e      r_state, w_state_d;
  logic [7:0]  r_idx, w_idx_d;
  logic        r_bad, w_bad_d;
  logic [7:0]  r_good_run, w_good_run_d;
  logic        r_pkt_ok, r_pkt_err, r_locked;
  logic        w_ok_d, w_err_d, w_word_err;
  logic [31:0] w_exp;

  assign w_exp = expected_word(r_idx);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= StHunt;
      r_idx      <= '0;
      r_bad      <= 1'b0;
      r_good_run <= '0;
      r_pkt_ok   <= 1'b0;
      r_pkt_err  <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_idx      <= w_idx_d;
      r_bad      <= w_bad_d;
      r_good_run <= w_good_run_d;
      r_pkt_ok   <= w_ok_d;
      r_pkt_err  <= w_err_d;
      // good_run only moves on a verdict, so lock tracks it directly.
      r_locked   <= (w_good_run_d >= LockTh);
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_idx_d      = r_idx;
    w_bad_d      = r_bad;
    w_good_run_d = r_good_run;
    w_ok_d       = 1'b0;
    w_err_d      = 1'b0;
    w_word_err   = 1'b0;
    if (DATA_VALID) begin
      unique case (r_state)
        StHunt: begin
          if (DATA_IN == HEADER_WORD) begin
            w_state_d = StPayload;
            w_idx_d   = '0;
            w_bad_d   = 1'b0;
          end
        end
        StPayload: begin
          if (DATA_IN == HEADER_WORD) begin
            // Abort and resync onto the new header.
            w_err_d      = 1'b1;
            w_good_run_d = '0;
            w_idx_d      = '0;
            w_bad_d      = 1'b0;
          end else begin
            if (DATA_IN != w_exp) begin
              w_bad_d    = 1'b1;
              w_word_err = 1'b1;
            end
            if (r_idx == LastIdx) begin
              w_state_d = StFooter;
            end else begin
              w_idx_d = r_idx + 8'd1;
            end
          end
        end
        StFooter: begin
          w_state_d = StHunt;
          if ((DATA_IN == FOOTER_WORD) && !r_bad) begin
            w_ok_d = 1'b1;
            if (r_good_run < LockTh) begin
              w_good_run_d = r_good_run + 8'd1;
            end
          end else begin
            w_err_d      = 1'b1;
            w_good_run_d = '0;
          end
        end
        default: w_state_d = StHunt;
      endcase
    end
  end

  assign LOCKED  = r_locked;
  assign PKT_OK  = r_pkt_ok;
  assign PKT_ERR = r_pkt_err;

  sat_counter #(.Width(32)) u_pkt_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .i_inc (w_ok_d),
    .i_clr (CLR_CNT),
    .o_cnt (PKT_CNT)
  );

  sat_counter #(.Width(32)) u_err_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .i_inc (w_err_d),
    .i_clr (CLR_CNT),
    .o_cnt (ERR_CNT)
  );

  sat_counter #(.Width(32)) u_word_err_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .i_inc (w_word_err),
    .i_clr (CLR_CNT),
    .o_cnt (WORD_ERR_CNT)
  );

`ifdef CHECK_DATA_PACKET_ERR_CAPTURE_EN
  logic [7:0]  r_err_idx;
  logic [31:0] r_err_exp, r_err_got;
  logic        r_err_valid;

  always_ff @(posedge CLK) begin
    if (RST || CLR_CNT) begin
      r_err_idx   <= '0;
      r_err_exp   <= '0;
      r_err_got   <= '0;
      r_err_valid <= 1'b0;
    end else if (w_word_err && !r_err_valid) begin
      r_err_idx   <= r_idx;
      r_err_exp   <= w_exp;
      r_err_got   <= DATA_IN;
      r_err_valid <= 1'b1;
    end
  end

  assign ERR_IDX   = r_err_idx;
  assign ERR_EXP   = r_err_exp;
  assign ERR_GOT   = r_err_got;
  assign ERR_VALID = r_err_valid;
`endif

endmodule

// File: tb/tb_check_data_packet.sv
// Directed self-checking bench for check_data_packet.
module tb_check_data_packet;

  localparam logic [31:0] Hdr = 32'hAAAAAAAA;
  localparam logic [31:0] Ftr = 32'hF0F0F0F0;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] DATA_IN;
  logic        DATA_VALID;
  logic        CLR_CNT;
  logic        LOCKED, PKT_OK, PKT_ERR;
  logic [31:0] PKT_CNT, ERR_CNT, WORD_ERR_CNT;
`ifdef CHECK_DATA_PACKET_ERR_CAPTURE_EN
  logic [7:0]  ERR_IDX;
  logic [31:0] ERR_EXP, ERR_GOT;
  logic        ERR_VALID;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int ok_seen = 0;
  int err_seen = 0;
  bit gaps_en = 1'b0;

  always #5 CLK = ~CLK;

  check_data_packet dut (
    .CLK          (CLK),
    .RST          (RST),
    .DATA_IN      (DATA_IN),
    .DATA_VALID   (DATA_VALID),
    .CLR_CNT      (CLR_CNT),
    .LOCKED       (LOCKED),
    .PKT_OK       (PKT_OK),
    .PKT_ERR      (PKT_ERR),
    .PKT_CNT      (PKT_CNT),
    .ERR_CNT      (ERR_CNT),
    .WORD_ERR_CNT (WORD_ERR_CNT)
`ifdef CHECK_DATA_PACKET_ERR_CAPTURE_EN
    ,
    .ERR_IDX      (ERR_IDX),
    .ERR_EXP      (ERR_EXP),
    .ERR_GOT      (ERR_GOT),
    .ERR_VALID    (ERR_VALID)
`endif
  );

  function automatic logic [31:0] pat(input int k);
    logic [15:0] lo;
    lo = 16'(2 * k);
    return {16'(2 * k + 1), lo};
  endfunction

  // One clock with the given inputs; returns #1 after the edge with pulses tallied.
  task automatic drive(input logic [31:0] d, input logic v);
    DATA_IN    = d;
    DATA_VALID = v;
    @(posedge CLK);
    #1;
    if (PKT_OK === 1'b1) ok_seen++;
    if (PKT_ERR === 1'b1) err_seen++;
  endtask

  task automatic put(input logic [31:0] d);
    if (gaps_en) begin
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) drive($urandom, 1'b0);
    end
    drive(d, 1'b1);
  endtask

  task automatic send_packet(input int bad_idx, input logic [31:0] bad_val,
                             input logic [31:0] footer, input bit clr_footer);
    put(Hdr);
    for (int k = 0; k < 24; k++) put((k == bad_idx) ? bad_val : pat(k));
    if (gaps_en) begin
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) drive($urandom, 1'b0);
    end
    CLR_CNT = clr_footer;
    drive(footer, 1'b1);
    CLR_CNT = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    CLR_CNT = 1'b0;
    drive(32'h0, 1'b0);
    drive(Hdr, 1'b1);
    n_cmp++; if (LOCKED !== 1'b0) begin n_err++; $display("FAIL rst_locked got=%b want=0", LOCKED); end
    n_cmp++; if (PKT_OK !== 1'b0) begin n_err++; $display("FAIL rst_ok got=%b want=0", PKT_OK); end
    n_cmp++; if (PKT_ERR !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b want=0", PKT_ERR); end
    n_cmp++; if (PKT_CNT !== 32'd0) begin n_err++; $display("FAIL rst_pkt_cnt got=%0d want=0", PKT_CNT); end
    n_cmp++; if (ERR_CNT !== 32'd0) begin n_err++; $display("FAIL rst_err_cnt got=%0d want=0", ERR_CNT); end
    n_cmp++; if (WORD_ERR_CNT !== 32'd0) begin n_err++; $display("FAIL rst_werr_cnt got=%0d want=0", WORD_ERR_CNT); end
    RST = 1'b0;
  endtask

  task automatic test_continuous();
    int ok0, err0;
    ok0 = ok_seen;
    err0 = err_seen;
    for (int p = 0; p < 100; p++) begin
      send_packet(-1, 32'h0, Ftr, 1'b0);
      n_cmp++; if (PKT_OK !== 1'b1) begin n_err++; $display("FAIL cont_ok pkt=%0d got=%b want=1", p, PKT_OK); end
      if (p == 0) begin
        n_cmp++; if (LOCKED !== 1'b0) begin n_err++; $display("FAIL cont_lock1 got=%b want=0", LOCKED); end
      end
      if (p == 1) begin
        n_cmp++; if (LOCKED !== 1'b1) begin n_err++; $display("FAIL cont_lock2 got=%b want=1", LOCKED); end
      end
    end
    n_cmp++; if (ok_seen - ok0 !== 100) begin n_err++; $display("FAIL cont_ok_pulses got=%0d want=100", ok_seen - ok0); end
    n_cmp++; if (err_seen - err0 !== 0) begin n_err++; $display("FAIL cont_err_pulses got=%0d want=0", err_seen - err0); end
    n_cmp++; if (PKT_CNT !== 32'd100) begin n_err++; $display("FAIL cont_pkt_cnt got=%0d want=100", PKT_CNT); end
    n_cmp++; if (ERR_CNT !== 32'd0) begin n_err++; $display("FAIL cont_err_cnt got=%0d want=0", ERR_CNT); end
    n_cmp++; if (WORD_ERR_CNT !== 32'd0) begin n_err++; $display("FAIL cont_werr_cnt got=%0d want=0", WORD_ERR_CNT); end
  endtask

  task automatic test_word_err();
    int err0;
    err0 = err_seen;
    send_packet(5, 32'h000B000B, Ftr, 1'b0);
    n_cmp++; if (PKT_ERR !== 1'b1) begin n_err++; $display("FAIL werr_pulse got=%b want=1", PKT_ERR); end
    n_cmp++; if (err_seen - err0 !== 1) begin n_err++; $display("FAIL werr_pulses got=%0d want=1", err_seen - err0); end
    n_cmp++; if (LOCKED !== 1'b0) begin n_err++; $display("FAIL werr_lock got=%b want=0", LOCKED); end
    n_cmp++; if (WORD_ERR_CNT !== 32'd1) begin n_err++; $display("FAIL werr_cnt got=%0d want=1", WORD_ERR_CNT); end
    n_cmp++; if (ERR_CNT !== 32'd1) begin n_err++; $display("FAIL werr_err_cnt got=%0d want=1", ERR_CNT); end
    n_cmp++; if (PKT_CNT !== 32'd100) begin n_err++; $display("FAIL werr_pkt_cnt got=%0d want=100", PKT_CNT); end
    send_packet(-1, 32'h0, Ftr, 1'b0);
    n_cmp++; if (LOCKED !== 1'b0) begin n_err++; $display("FAIL werr_relock1 got=%b want=0", LOCKED); end
    send_packet(-1, 32'h0, Ftr, 1'b0);
    n_cmp++; if (LOCKED !== 1'b1) begin n_err++; $display("FAIL werr_relock2 got=%b want=1", LOCKED); end
    n_cmp++; if (PKT_CNT !== 32'd102) begin n_err++; $display("FAIL werr_pkt_cnt2 got=%0d want=102", PKT_CNT); end
  endtask

  task automatic test_clear_and_footer();
    CLR_CNT = 1'b1;
    drive(32'h0, 1'b0);
    CLR_CNT = 1'b0;
    n_cmp++; if (PKT_CNT !== 32'd0) begin n_err++; $display("FAIL clr_pkt_cnt got=%0d want=0", PKT_CNT); end
    n_cmp++; if (WORD_ERR_CNT !== 32'd0) begin n_err++; $display("FAIL clr_werr_cnt got=%0d want=0", WORD_ERR_CNT); end
    n_cmp++; if (LOCKED !== 1'b1) begin n_err++; $display("FAIL clr_keeps_lock got=%b want=1", LOCKED); end
    send_packet(-1, 32'h0, 32'hF0F0F0F1, 1'b0);
    n_cmp++; if (PKT_ERR !== 1'b1) begin n_err++; $display("FAIL ftr_pulse got=%b want=1", PKT_ERR); end
    n_cmp++; if (ERR_CNT !== 32'd1) begin n_err++; $display("FAIL ftr_err_cnt got=%0d want=1", ERR_CNT); end
    n_cmp++; if (WORD_ERR_CNT !== 32'd0) begin n_err++; $display("FAIL ftr_werr_cnt got=%0d want=0", WORD_ERR_CNT); end
    n_cmp++; if (LOCKED !== 1'b0) begin n_err++; $display("FAIL ftr_lock got=%b want=0", LOCKED); end
    // Header lands on the very next cycle after the bad footer.
    send_packet(-1, 32'h0, Ftr, 1'b0);
    n_cmp++; if (PKT_OK !== 1'b1) begin n_err++; $display("FAIL b2b_ok got=%b want=1", PKT_OK); end
    n_cmp++; if (PKT_CNT !== 32'd1) begin n_err++; $display("FAIL b2b_pkt_cnt got=%0d want=1", PKT_CNT); end
  endtask

  task automatic test_abort();
    put(Hdr);
    for (int k = 0; k < 10; k++) put(pat(k));
    put(Hdr);
    n_cmp++; if (PKT_ERR !== 1'b1) begin n_err++; $display("FAIL abort_pulse got=%b want=1", PKT_ERR); end
    n_cmp++; if (ERR_CNT !== 32'd2) begin n_err++; $display("FAIL abort_err_cnt got=%0d want=2", ERR_CNT); end
    n_cmp++; if (WORD_ERR_CNT !== 32'd0) begin n_err++; $display("FAIL abort_werr got=%0d want=0", WORD_ERR_CNT); end
    for (int k = 0; k < 24; k++) put(pat(k));
    put(Ftr);
    n_cmp++; if (PKT_OK !== 1'b1) begin n_err++; $display("FAIL abort_then_ok got=%b want=1", PKT_OK); end
    n_cmp++; if (PKT_CNT !== 32'd2) begin n_err++; $display("FAIL abort_pkt_cnt got=%0d want=2", PKT_CNT); end
  endtask

  task automatic test_gaps();
    int ok0, err0;
    gaps_en = 1'b1;
    ok0 = ok_seen;
    err0 = err_seen;
    for (int p = 0; p < 4; p++) send_packet(-1, 32'h0, Ftr, 1'b0);
    n_cmp++; if (ok_seen - ok0 !== 4) begin n_err++; $display("FAIL gap_ok_pulses got=%0d want=4", ok_seen - ok0); end
    n_cmp++; if (err_seen - err0 !== 0) begin n_err++; $display("FAIL gap_err_pulses got=%0d want=0", err_seen - err0); end
    n_cmp++; if (PKT_CNT !== 32'd6) begin n_err++; $display("FAIL gap_pkt_cnt got=%0d want=6", PKT_CNT); end
    send_packet(-1, 32'h0, Ftr, 1'b1);
    n_cmp++; if (PKT_OK !== 1'b1) begin n_err++; $display("FAIL gapclr_ok got=%b want=1", PKT_OK); end
    n_cmp++; if (PKT_CNT !== 32'd0) begin n_err++; $display("FAIL gapclr_pkt_cnt got=%0d want=0", PKT_CNT); end
    n_cmp++; if (ERR_CNT !== 32'd0) begin n_err++; $display("FAIL gapclr_err_cnt got=%0d want=0", ERR_CNT); end
    send_packet(-1, 32'h0, Ftr, 1'b0);
    n_cmp++; if (PKT_CNT !== 32'd1) begin n_err++; $display("FAIL gapafter_pkt_cnt got=%0d want=1", PKT_CNT); end
    gaps_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ok0, err0;
    put(Hdr);
    for (int k = 0; k < 12; k++) put(pat(k));
    RST = 1'b1;
    drive(pat(12), 1'b1);
    RST = 1'b0;
    n_cmp++; if ({LOCKED, PKT_OK, PKT_ERR} !== 3'b000) begin n_err++; $display("FAIL rstmid_flags got=%b want=000", {LOCKED, PKT_OK, PKT_ERR}); end
    n_cmp++; if ({PKT_CNT, ERR_CNT, WORD_ERR_CNT} !== 96'd0) begin n_err++; $display("FAIL rstmid_cnts got=%0d/%0d/%0d want=0/0/0", PKT_CNT, ERR_CNT, WORD_ERR_CNT); end
    ok0 = ok_seen;
    err0 = err_seen;
    for (int k = 13; k < 24; k++) put(pat(k));
    put(Ftr);
    n_cmp++; if ((ok_seen - ok0) + (err_seen - err0) !== 0) begin n_err++; $display("FAIL rstmid_ignored got=%0d want=0", (ok_seen - ok0) + (err_seen - err0)); end
    n_cmp++; if (WORD_ERR_CNT !== 32'd0) begin n_err++; $display("FAIL rstmid_werr got=%0d want=0", WORD_ERR_CNT); end
    send_packet(-1, 32'h0, Ftr, 1'b0);
    n_cmp++; if (PKT_OK !== 1'b1) begin n_err++; $display("FAIL rstmid_next_ok got=%b want=1", PKT_OK); end
    n_cmp++; if (PKT_CNT !== 32'd1) begin n_err++; $display("FAIL rstmid_pkt_cnt got=%0d want=1", PKT_CNT); end
  endtask

  initial begin
    RST = 1'b1;
    DATA_IN = '0;
    DATA_VALID = 1'b0;
    CLR_CNT = 1'b0;
    @(negedge CLK);
    test_reset();
    test_continuous();
    test_word_err();
    test_clear_and_footer();
    test_abort();
    test_gaps();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
